shift_rows_pipe: RTL

SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

---
 rtl/aes_dec_pkg.sv | 13 +
 rtl/shift_rows_perm.sv | 30 +++
 rtl/shift_rows_pipe.sv | 63 ++++++
 3 files changed

// File: rtl/aes_dec_pkg.sv
// Shared AES state geometry and ShiftRows mode encoding.
package aes_dec_pkg;
   localparam int NB    = 4;
   localparam int NROWS = 4;
   localparam int NELEM = NB * NROWS;

   typedef enum logic {MODE_FWD = 1'b0, MODE_INV = 1'b1} mode_e;

   // Column-major element index of row r, column c.
   function automatic int elem_idx(input int r, input int c);
      return r + NROWS * c;
   endfunction
endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows permutation. The forward path exists only when
// SHIFT_ROWS_FWD_EN is defined; otherwise the block is inverse-only.
module shift_rows_perm
   import aes_dec_pkg::*;
#(
   parameter int ELEM_W = 8
) (
   input  logic [NELEM*ELEM_W-1:0] data,
   input  logic                    inv,
   output logic [NELEM*ELEM_W-1:0] result
);
   for (genvar r = 0; r < NROWS; r++) begin : g_row
      for (genvar c = 0; c < NB; c++) begin : g_col
         localparam int DST     = elem_idx(r, c);
         localparam int INV_SRC = elem_idx(r, (c - r + NB) % NB);
`ifdef SHIFT_ROWS_FWD_EN
         localparam int FWD_SRC = elem_idx(r, (c + r) % NB);
         assign result[DST*ELEM_W +: ELEM_W] = (inv == MODE_INV) ?
            data[INV_SRC*ELEM_W +: ELEM_W] : data[FWD_SRC*ELEM_W +: ELEM_W];
`else
         assign result[DST*ELEM_W +: ELEM_W] = data[INV_SRC*ELEM_W +: ELEM_W];
`endif
      end
   end

`ifndef SHIFT_ROWS_FWD_EN
   logic unused_inv;
   assign unused_inv = inv;
`endif
endmodule

// File: rtl/shift_rows_pipe.sv
// ShiftRows stage with a DEPTH-entry result FIFO and valid/ready handshakes.
// Define SHIFT_ROWS_FWD_EN to honour in_inv per transaction.
module shift_rows_pipe
   import aes_dec_pkg::*;
#(
   parameter int ELEM_W = 8,
   parameter int DEPTH  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NELEM*ELEM_W-1:0] in_data,
   input  logic                    in_inv,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [NELEM*ELEM_W-1:0] out_data
);
   localparam int DW = NELEM * ELEM_W;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [DW-1:0] perm_data;
   logic          push, pop;

   // Entries hold the already-permuted state, so the selected mode
   // travels with each transaction.
   shift_rows_perm #(.ELEM_W(ELEM_W)) u_perm (
      .data   (in_data),
      .inv    (in_inv),
      .result (perm_data)
   );

   assign in_ready  = (count < CW'(DEPTH));
   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= perm_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule
